// File: rtl/conv_pkg.sv
// Shared types and helpers for the sequential convolution layer.
// State encoding, default data width and the ReLU rule.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_e;

    localparam int DEF_BITWIDTH = 32;

    // Zero the result when ReLU is enabled and the sum is negative.
    function automatic logic relu_zero(input logic en, input logic msb);
        return en & msb;
    endfunction

endpackage

// File: rtl/conv_window_dot.sv
// Combinational KxK multiply-and-sum over one channel window.
// Products keep their low BITWIDTH bits; the sum wraps.
module conv_window_dot #(
    parameter int BITWIDTH = 32,
    parameter int K        = 5
) (
    input  logic [K-1:0][K-1:0][BITWIDTH-1:0] win,
    input  logic [K-1:0][K-1:0][BITWIDTH-1:0] wts,
    output logic [BITWIDTH-1:0]               sum
);

    // Accumulate every truncated product of the window.
    always_comb begin
        sum = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                sum = sum + BITWIDTH'(win[r][c] * wts[r][c]);
            end
        end
    end

endmodule

// File: rtl/conv_layer_seq.sv
// Sequential conv layer: one dot unit shared over channels and kernels,
// results streamed out one per valid/ready transfer.
module conv_layer_seq
    import conv_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int IN_CH    = 2,
    parameter int OUT_CH   = 10,
    parameter int K        = 5,
    parameter int IDXW     = (OUT_CH > 1 ? $clog2(OUT_CH) : 1)
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic                                              relu_en,
    input  logic [IN_CH-1:0][K-1:0][K-1:0][BITWIDTH-1:0]      featuremap,
    input  logic [OUT_CH-1:0][IN_CH-1:0][K-1:0][K-1:0][BITWIDTH-1:0] kernel,
    output logic                                              busy,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [BITWIDTH-1:0]                               out_data,
    output logic [IDXW-1:0]                                   out_index,
    output logic                                              done
);

    localparam int CHW = (IN_CH > 1 ? $clog2(IN_CH) : 1);

    state_e              state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [IDXW-1:0]     k_q, k_d;
    logic [BITWIDTH-1:0] acc_q, acc_d;
    logic                relu_q, relu_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [BITWIDTH-1:0] data_q, data_d;
    logic [IDXW-1:0]     index_q, index_d;
    logic                done_q, done_d;

    logic [BITWIDTH-1:0] dot;
    logic [BITWIDTH-1:0] sum_w;
    logic                last_ch;
    logic                last_k;

    conv_window_dot #(
        .BITWIDTH(BITWIDTH),
        .K       (K)
    ) u_dot (
        .win(featuremap[ch_q]),
        .wts(kernel[k_q][ch_q]),
        .sum(dot)
    );

    assign sum_w   = acc_q + dot;
    assign last_ch = (ch_q == CHW'(IN_CH - 1));
    assign last_k  = (k_q == IDXW'(OUT_CH - 1));

    // State and datapath registers; reset abandons any computation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            relu_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            relu_q  <= relu_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

    // Next-state: one ACC cycle per channel, HOLD until the result is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = ACC;
            ACC:  if (last_ch) state_d = HOLD;
            HOLD: if (out_ready) state_d = last_k ? IDLE : ACC;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output updates for each state.
    always_comb begin
        ch_d    = ch_q;
        k_d     = k_q;
        acc_d   = acc_q;
        relu_d  = relu_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    relu_d = relu_en;
                    ch_d   = '0;
                    k_d    = '0;
                    acc_d  = '0;
                    busy_d = 1'b1;
                end
            end
            ACC: begin
                acc_d = sum_w;
                if (last_ch) begin
                    data_d  = relu_zero(relu_q, sum_w[BITWIDTH-1]) ? '0 : sum_w;
                    valid_d = 1'b1;
                    index_d = k_q;
                end else begin
                    ch_d = ch_q + CHW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (last_k) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        k_d   = k_q + IDXW'(1);
                        ch_d  = '0;
                        acc_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Scoreboard bench for conv_layer_seq: randomized and directed windows
// against a plain-arithmetic reference, plus a tiny 1x1x3 instance.
module tb_conv_layer_seq;

    localparam int BW   = 32;
    localparam int IC   = 2;
    localparam int OC   = 10;
    localparam int KK   = 5;
    localparam int IW   = 4;
    localparam int NLAT = OC * (IC + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0;
    logic relu_en = 1'b0;
    logic [IC-1:0][KK-1:0][KK-1:0][BW-1:0] fm;
    logic [OC-1:0][IC-1:0][KK-1:0][KK-1:0][BW-1:0] kern;
    logic busy, out_valid, done;
    logic out_ready = 1'b1;
    logic [BW-1:0] out_data;
    logic [IW-1:0] out_index;

    conv_layer_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .relu_en   (relu_en),
        .featuremap(fm),
        .kernel    (kern),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .done      (done)
    );

    logic s_start = 1'b0;
    logic [0:0][2:0][2:0][BW-1:0] s_fm;
    logic [0:0][0:0][2:0][2:0][BW-1:0] s_kern;
    logic s_busy, s_valid, s_done;
    logic [BW-1:0] s_data;
    logic [0:0] s_index;

    conv_layer_seq #(
        .BITWIDTH(BW),
        .IN_CH   (1),
        .OUT_CH  (1),
        .K       (3)
    ) dut_s (
        .clk       (clk),
        .rst       (rst),
        .start     (s_start),
        .relu_en   (1'b0),
        .featuremap(s_fm),
        .kernel    (s_kern),
        .busy      (s_busy),
        .out_valid (s_valid),
        .out_ready (1'b1),
        .out_data  (s_data),
        .out_index (s_index),
        .done      (s_done)
    );

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [IW-1:0] idx;
        logic [BW-1:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every transfer; held outputs must not move.
    logic stall_prev = 1'b0;
    logic [BW-1:0] prev_data;
    logic [IW-1:0] prev_idx;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_data", 64'(out_data), 64'(prev_data));
                check("hold_index", 64'(out_index), 64'(prev_idx));
                check("hold_valid", 64'(out_valid), 64'd1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", 64'(out_index), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_index", 64'(out_index), 64'(e.idx));
                    check("out_data", 64'(out_data), 64'(e.data));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_idx = out_index;
        end
    end

    // Build the operands for a pattern and queue the expected results.
    task automatic load(input int mode, input bit relu);
        for (int c = 0; c < IC; c++)
            for (int r = 0; r < KK; r++)
                for (int s = 0; s < KK; s++) begin
                    case (mode)
                        2: fm[c][r][s] = 32'h0001_0000;
                        3: fm[c][r][s] = 32'h7FFF_FFFF;
                        4: fm[c][r][s] = $urandom;
                        default: fm[c][r][s] = 32'd1;
                    endcase
                    for (int k = 0; k < OC; k++) begin
                        case (mode)
                            1: kern[k][c][r][s] = (k % 2 == 1) ? 32'hFFFF_FFFF : 32'd1;
                            2: kern[k][c][r][s] = 32'h0001_0000;
                            4: kern[k][c][r][s] = $urandom;
                            default: kern[k][c][r][s] = 32'd1;
                        endcase
                    end
                end
        for (int k = 0; k < OC; k++) begin
            longint unsigned tot;
            exp_t e;
            tot = 0;
            for (int c = 0; c < IC; c++)
                for (int r = 0; r < KK; r++)
                    for (int s = 0; s < KK; s++)
                        tot += (longint'(fm[c][r][s]) * longint'(kern[k][c][r][s]))
                               % 64'h1_0000_0000;
            e.idx = IW'(k);
            e.data = BW'(tot % 64'h1_0000_0000);
            if (relu && e.data[BW-1]) e.data = '0;
            sb.push_back(e);
        end
    endtask

    // ready_mode: 0 always ready, 1 five-cycle stall on index 3, 2 random.
    task automatic run(input int mode, input bit relu, input int ready_mode,
                       input bit poke, input bit abort);
        int cyc, stalls, held, first_v, dcount;
        bit got_done;
        load(mode, relu);
        @(posedge clk); #1;
        start = 1'b1;
        relu_en = relu;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        relu_en = 1'b0;
        cyc = 0; stalls = 0; held = 0; first_v = -1; got_done = 1'b0;
        while (cyc < 2000) begin
            case (ready_mode)
                1: out_ready = !(out_valid && out_index == 4'd3 && held < 5);
                2: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
            if (out_valid && !out_ready) begin
                stalls++;
                held++;
            end
            start = poke && (cyc == 5 || cyc == 9);
            relu_en = start;
            if (abort && cyc == 12) rst = 1'b1;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            relu_en = 1'b0;
            if (abort && cyc == 13) break;
            if (first_v < 0 && out_valid) first_v = cyc;
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        if (abort) begin
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_valid", 64'(out_valid), 64'd0);
            rst = 1'b0;
            sb.delete();
            dcount = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (done) dcount++;
            end
            check("abort_no_done", 64'(dcount), 64'd0);
        end else begin
            check("done_seen", 64'(got_done), 64'd1);
            check("first_valid_lat", 64'(first_v), 64'(IC));
            check("done_lat", 64'(cyc), 64'(NLAT + stalls));
            if (ready_mode == 1) check("stall_cycles", 64'(stalls), 64'd5);
            check("sb_drained", 64'(sb.size()), 64'd0);
            @(posedge clk); #1;
            check("done_pulse", 64'(done), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        fm = '0;
        kern = '0;
        s_fm = '0;
        s_kern = '0;
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 3; s++) begin
                s_fm[0][r][s] = 32'd1;
                s_kern[0][0][r][s] = 32'd1;
            end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_index", 64'(out_index), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        run(0, 1'b0, 0, 1'b0, 1'b0);
        run(0, 1'b0, 1, 1'b0, 1'b0);
        run(1, 1'b0, 0, 1'b0, 1'b0);
        run(1, 1'b1, 0, 1'b0, 1'b0);
        run(0, 1'b0, 0, 1'b1, 1'b0);
        run(4, 1'b0, 0, 1'b0, 1'b1);
        run(0, 1'b0, 0, 1'b0, 1'b0);
        run(2, 1'b0, 0, 1'b0, 1'b0);
        run(3, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run(4, 1'(i % 2), 2, 1'b0, 1'b0);

        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        check("s_busy", 64'(s_busy), 64'd1);
        check("s_valid_early", 64'(s_valid), 64'd0);
        @(posedge clk); #1;
        check("s_valid", 64'(s_valid), 64'd1);
        check("s_data", 64'(s_data), 64'd9);
        check("s_index", 64'(s_index), 64'd0);
        @(posedge clk); #1;
        check("s_done", 64'(s_done), 64'd1);
        check("s_valid_off", 64'(s_valid), 64'd0);
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        check("s_restart_busy", 64'(s_busy), 64'd1);
        check("s_done_pulse", 64'(s_done), 64'd0);
        @(posedge clk); #1;
        check("s_valid2", 64'(s_valid), 64'd1);
        check("s_data2", 64'(s_data), 64'd9);
        @(posedge clk); #1;
        check("s_done2", 64'(s_done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
